// File: rtl/abro_n_state_machine.sv
// abro_n_state_machine: N-input ABRO controller with level/edge capture, hold/pulse output and optional re-arm
module abro_n_state_machine #(
    parameter int N          = 2,
    parameter int EDGE_MODE  = 0,
    parameter int PULSE_OUT  = 0,
    parameter int AUTO_REARM = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in,
    output logic             o,
    output logic [1:0]       state,
    output logic [N-1:0]     seen,
    output logic [CNT_W-1:0] count
);
    typedef enum logic [1:0] {WAIT = 2'b00, DONE = 2'b01, REARM = 2'b10} state_t;
    localparam logic [N-1:0] FULL = '1;
    state_t state_nxt;
    logic [N-1:0] in_q, hit, seen_nxt;
    logic o_nxt, inc;
    assign hit = EDGE_MODE != 0 ? in & ~in_q : in;
    always_comb begin
        state_nxt = WAIT;
        seen_nxt = '0;
        inc = 1'b0;
        case (state)
            WAIT: begin
                seen_nxt = seen | hit;
                inc = &(seen | hit);
                state_nxt = inc ? DONE : WAIT;
            end
            DONE: begin
                seen_nxt = FULL;
                state_nxt = AUTO_REARM != 0 ? REARM : DONE;
            end
            REARM: begin
                seen_nxt = in == '0 ? '0 : FULL;
                state_nxt = in == '0 ? WAIT : REARM;
            end
            default: ;
        endcase
        o_nxt = state_nxt == DONE && (PULSE_OUT == 0 || state == WAIT);
    end
    always_ff @(posedge clk) begin
        in_q <= in;
        if (reset) begin
            state <= WAIT;
            seen <= '0;
            o <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nxt;
            seen <= seen_nxt;
            o <= o_nxt;
            count <= (inc && count != '1) ? count + 1'b1 : count;
        end
    end
endmodule

// File: tb/tb_abro_n_state_machine.sv
// tb_abro_n_state_machine: directed plan plus random traffic on five configurations against a round-level model
module tb_abro_n_state_machine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2, rst3, rst4;
    logic [1:0] in0, in1, in3, in4;
    logic [2:0] in2;
    logic o0, o1, o2, o3, o4;
    logic [1:0] st0, st1, st2, st3, st4;
    logic [1:0] sn0, sn1, sn3, sn4;
    logic [2:0] sn2;
    logic [7:0] c0, c1, c2, c3;
    logic [1:0] c4;

    abro_n_state_machine #(.N(2)) u0 (.clk(clk), .reset(rst0), .in(in0), .o(o0), .state(st0), .seen(sn0), .count(c0));
    abro_n_state_machine #(.N(2), .EDGE_MODE(1)) u1 (.clk(clk), .reset(rst1), .in(in1), .o(o1), .state(st1), .seen(sn1), .count(c1));
    abro_n_state_machine #(.N(3)) u2 (.clk(clk), .reset(rst2), .in(in2), .o(o2), .state(st2), .seen(sn2), .count(c2));
    abro_n_state_machine #(.N(2), .AUTO_REARM(1), .PULSE_OUT(1)) u3 (.clk(clk), .reset(rst3), .in(in3), .o(o3), .state(st3), .seen(sn3), .count(c3));
    abro_n_state_machine #(.N(2), .AUTO_REARM(1), .CNT_W(2)) u4 (.clk(clk), .reset(rst4), .in(in4), .o(o4), .state(st4), .seen(sn4), .count(c4));

    // Round-level view: phase 0 collecting, 1 completed, 2 waiting for all-low
    typedef struct {
        int ph;
        logic [15:0] seen;
        logic o;
        int cnt;
        logic [15:0] inq;
    } mdl_t;
    mdl_t m [5];
    int checks = 0;
    int errors = 0;

    function automatic mdl_t mstep(mdl_t p, int n, bit em, bit po, bit ar, int cw, logic r, logic [15:0] x);
        mdl_t q;
        logic [15:0] full, hit;
        q = p;
        full = 16'((17'h1 << n) - 1);
        hit = em ? x & ~p.inq : x;
        q.inq = x;
        if (r) begin
            q.ph = 0; q.seen = '0; q.o = 1'b0; q.cnt = 0;
        end else if (p.ph == 0) begin
            q.seen = p.seen | hit;
            q.o = 1'b0;
            if (q.seen == full) begin
                q.ph = 1;
                q.o = 1'b1;
                q.cnt = p.cnt < (1 << cw) - 1 ? p.cnt + 1 : p.cnt;
            end
        end else if (p.ph == 1) begin
            q.ph = ar ? 2 : 1;
            q.o = !ar && !po;
        end else begin
            q.o = 1'b0;
            if (x == '0) begin
                q.ph = 0; q.seen = '0;
            end
        end
        return q;
    endfunction

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", t, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("u0.state", 32'(st0), 32'(m[0].ph)); chk("u0.seen", 32'(sn0), 32'(m[0].seen));
        chk("u0.o", 32'(o0), 32'(m[0].o)); chk("u0.count", 32'(c0), 32'(m[0].cnt));
        chk("u1.state", 32'(st1), 32'(m[1].ph)); chk("u1.seen", 32'(sn1), 32'(m[1].seen));
        chk("u1.o", 32'(o1), 32'(m[1].o)); chk("u1.count", 32'(c1), 32'(m[1].cnt));
        chk("u2.state", 32'(st2), 32'(m[2].ph)); chk("u2.seen", 32'(sn2), 32'(m[2].seen));
        chk("u2.o", 32'(o2), 32'(m[2].o)); chk("u2.count", 32'(c2), 32'(m[2].cnt));
        chk("u3.state", 32'(st3), 32'(m[3].ph)); chk("u3.seen", 32'(sn3), 32'(m[3].seen));
        chk("u3.o", 32'(o3), 32'(m[3].o)); chk("u3.count", 32'(c3), 32'(m[3].cnt));
        chk("u4.state", 32'(st4), 32'(m[4].ph)); chk("u4.seen", 32'(sn4), 32'(m[4].seen));
        chk("u4.o", 32'(o4), 32'(m[4].o)); chk("u4.count", 32'(c4), 32'(m[4].cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        m[0] = mstep(m[0], 2, 1'b0, 1'b0, 1'b0, 8, rst0, 16'(in0));
        m[1] = mstep(m[1], 2, 1'b1, 1'b0, 1'b0, 8, rst1, 16'(in1));
        m[2] = mstep(m[2], 3, 1'b0, 1'b0, 1'b0, 8, rst2, 16'(in2));
        m[3] = mstep(m[3], 2, 1'b0, 1'b1, 1'b1, 8, rst3, 16'(in3));
        m[4] = mstep(m[4], 2, 1'b0, 1'b0, 1'b1, 2, rst4, 16'(in4));
    endtask

    task automatic step();
        tick();
        #1 check_all();
    endtask

    initial begin
        for (int i = 0; i < 5; i++) m[i] = '{0, 16'h0, 1'b0, 0, 16'h0};
        {rst0, rst1, rst2, rst3, rst4} = 5'b11111;
        in0 = 2'b11; in1 = 2'b11; in2 = 3'b000; in3 = 2'b00; in4 = 2'b00;
        step(); step();
        chk("rst.o", 32'(o0), 32'd0); chk("rst.state", 32'(st0), 32'd0);
        chk("rst.count", 32'(c0), 32'd0); chk("rst.seen", 32'(sn2), 32'd0);
        // level mode: inputs high through reset complete on the first released edge
        rst0 = 1'b0; step();
        chk("A.o", 32'(o0), 32'd1); chk("A.state", 32'(st0), 32'd1); chk("A.count", 32'(c0), 32'd1);
        in0 = 2'b00; repeat (3) step();
        chk("A.hold_o", 32'(o0), 32'd1); chk("A.hold_seen", 32'(sn0), 32'd3);
        rst0 = 1'b1; step();
        chk("A.rst_o", 32'(o0), 32'd0); chk("A.rst_count", 32'(c0), 32'd0); chk("A.rst_seen", 32'(sn0), 32'd0);
        rst0 = 1'b0; step();
        // edge mode: inputs held across release must not count
        rst1 = 1'b0; step(); step();
        chk("B.held_o", 32'(o1), 32'd0); chk("B.held_seen", 32'(sn1), 32'd0);
        in1 = 2'b00; step();
        in1 = 2'b01; step();
        chk("B.a_o", 32'(o1), 32'd0); chk("B.a_seen", 32'(sn1), 32'd1);
        in1 = 2'b11; step();
        chk("B.b_o", 32'(o1), 32'd1); chk("B.b_count", 32'(c1), 32'd1);
        // staggered capture on three channels
        rst2 = 1'b0; in2 = 3'b001; step(); chk("C.seen1", 32'(sn2), 32'd1);
        in2 = 3'b010; step(); chk("C.seen2", 32'(sn2), 32'd3); chk("C.o2", 32'(o2), 32'd0);
        in2 = 3'b100; step(); chk("C.seen3", 32'(sn2), 32'd7); chk("C.o3", 32'(o2), 32'd1);
        in2 = 3'b000; rst2 = 1'b1; step();
        rst2 = 1'b0; in2 = 3'b001; step();
        in2 = 3'b010; step();
        in2 = 3'b100; rst2 = 1'b1; step();
        chk("C.rst_o", 32'(o2), 32'd0); chk("C.rst_seen", 32'(sn2), 32'd0); chk("C.rst_state", 32'(st2), 32'd0);
        in2 = 3'b000; rst2 = 1'b0; step();
        // auto re-arm with pulse output, three rounds
        rst3 = 1'b0;
        for (int r = 0; r < 3; r++) begin
            in3 = 2'b11; step();
            chk("D.o", 32'(o3), 32'd1); chk("D.done", 32'(st3), 32'd1); chk("D.count", 32'(c3), 32'(r + 1));
            step(); chk("D.pulse_end", 32'(o3), 32'd0); chk("D.rearm", 32'(st3), 32'd2);
            step(); chk("D.rearm_hold", 32'(st3), 32'd2);
            in3 = 2'b00; step(); chk("D.wait", 32'(st3), 32'd0); chk("D.seen_clr", 32'(sn3), 32'd0);
        end
        chk("D.total", 32'(c3), 32'd3);
        // saturating two-bit counter
        rst4 = 1'b0;
        for (int r = 0; r < 5; r++) begin
            in4 = 2'b11; step();
            chk("E.count", 32'(c4), 32'(r < 3 ? r + 1 : 3));
            in4 = 2'b00; step(); step();
            chk("E.wait", 32'(st4), 32'd0);
        end
        // illegal state recovery
        in0 = 2'b11; step(); chk("F.pre", 32'(st0), 32'd1);
        in0 = 2'b00;
        force u0.state = 2'b11;
        tick();
        m[0].ph = 0; m[0].seen = '0; m[0].o = 1'b0;
        #1 chk("F.seen", 32'(sn0), 32'd0); chk("F.o", 32'(o0), 32'd0);
        release u0.state;
        step(); chk("F.state", 32'(st0), 32'd0); chk("F.seen2", 32'(sn0), 32'd0);
        // random traffic with occasional resets
        repeat (400) begin
            rst0 = $urandom_range(0, 19) == 0; rst1 = $urandom_range(0, 19) == 0;
            rst2 = $urandom_range(0, 19) == 0; rst3 = $urandom_range(0, 19) == 0;
            rst4 = $urandom_range(0, 19) == 0;
            in0 = 2'($urandom_range(0, 3)); in1 = 2'($urandom_range(0, 3));
            in2 = 3'($urandom_range(0, 7)); in3 = 2'($urandom_range(0, 3));
            in4 = 2'($urandom_range(0, 3));
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
